// File: rtl/mem_access_ctrl_pkg.sv
// Shared types for the memory-stage access controller: FSM states, data/address
// widths and the abort-cause encoding.
package mem_access_ctrl_pkg;

  localparam int DATA_W = 16;
  localparam int ADDR_W = 16;

  typedef enum logic [1:0] {
    IDLE,
    RETRY,
    WAIT
  } state_t;

  typedef enum logic [1:0] {
    ERR_NONE,
    ERR_TIMEOUT,
    ERR_ALIGN
  } err_cause_t;

endpackage

// File: rtl/mem_access_ctrl_wdog_cnt.sv
// Watchdog counter bounding the WAIT phase of a memory access; tc rises when the
// count reaches TIMEOUT_CYC and the counter then saturates until cleared.
module mem_wdog_cnt #(
  parameter int TIMEOUT_CYC = 31
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic tc
);

  localparam int W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [W-1:0] TC_VAL = W'(TIMEOUT_CYC);

  logic [W-1:0] count;

  assign tc = (count == TC_VAL);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && !tc) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/mem_access_ctrl.sv
// Memory-stage access controller: issues loads/stores to a stalling data memory,
// freezes the pipeline while busy, and aborts on watchdog timeout.
// Optional MEM_ACCESS_ALIGN_CHK_EN rejects odd byte addresses with errM.
module mem_access_ctrl
  import mem_access_ctrl_pkg::*;
#(
  parameter int TIMEOUT_CYC = 31
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              readEnM,
  input  logic              memWrtM,
  input  logic [ADDR_W-1:0] aluFinalM,
  input  logic [DATA_W-1:0] wrtDataM,
  output logic              mem_en,
  output logic              mem_wr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_stall,
  input  logic              mem_done,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              stallM,
  output logic [DATA_W-1:0] readDataM,
  output logic              errM
);

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic              wr_q;
  logic [DATA_W-1:0] rdata_q, rd_nxt;
  logic              req, misalign;
  logic              latch, capture, zero_rd;
  logic              wd_clr, wd_en, wd_tc;
  err_cause_t        err_cause;

  assign req = readEnM | memWrtM;

`ifdef MEM_ACCESS_ALIGN_CHK_EN
  assign misalign = aluFinalM[0];
`else
  assign misalign = 1'b0;
`endif

  mem_wdog_cnt #(
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) u_wdog (
    .clk    (clk),
    .rst    (rst),
    .clear  (wd_clr),
    .enable (wd_en),
    .tc     (wd_tc)
  );

  always_comb begin
    state_nxt = state;
    mem_en    = 1'b0;
    mem_wr    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    stallM    = 1'b0;
    latch     = 1'b0;
    capture   = 1'b0;
    zero_rd   = 1'b0;
    wd_clr    = 1'b0;
    wd_en     = 1'b0;
    err_cause = ERR_NONE;
    readDataM = '0;
    errM      = 1'b0;

    case (state)
      IDLE: begin
        if (req && misalign) begin
          err_cause = ERR_ALIGN;
        end else if (req) begin
          mem_en    = 1'b1;
          mem_wr    = memWrtM;
          mem_addr  = aluFinalM;
          mem_wdata = wrtDataM;
          latch     = 1'b1;
          if (mem_stall) begin
            state_nxt = RETRY;
            stallM    = 1'b1;
          end else if (mem_done) begin
            capture = !memWrtM;
          end else begin
            state_nxt = WAIT;
            stallM    = 1'b1;
            wd_clr    = 1'b1;
          end
        end
      end
      // Replays the latched request so a busy memory sees a stable access.
      RETRY: begin
        mem_en    = 1'b1;
        mem_wr    = wr_q;
        mem_addr  = addr_q;
        mem_wdata = wdata_q;
        if (mem_stall) begin
          stallM = 1'b1;
        end else if (mem_done) begin
          state_nxt = IDLE;
          capture   = !wr_q;
        end else begin
          state_nxt = WAIT;
          stallM    = 1'b1;
          wd_clr    = 1'b1;
        end
      end
      WAIT: begin
        if (mem_done) begin
          state_nxt = IDLE;
          capture   = !wr_q;
        end else if (wd_tc) begin
          state_nxt = IDLE;
          zero_rd   = 1'b1;
          err_cause = ERR_TIMEOUT;
        end else begin
          stallM = 1'b1;
          wd_en  = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase

    rd_nxt = rdata_q;
    if (capture) begin
      rd_nxt = mem_rdata;
    end else if (zero_rd) begin
      rd_nxt = '0;
    end

    // Outputs are combinational, so force them quiet while reset is held.
    if (!rst) begin
      mem_en    = 1'b0;
      mem_wr    = 1'b0;
      mem_addr  = '0;
      mem_wdata = '0;
      stallM    = 1'b0;
    end else begin
      readDataM = rd_nxt;
      errM      = (err_cause != ERR_NONE);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      wr_q    <= 1'b0;
      rdata_q <= '0;
    end else begin
      state   <= state_nxt;
      rdata_q <= rd_nxt;
      if (latch) begin
        addr_q  <= aluFinalM;
        wdata_q <= wrtDataM;
        wr_q    <= memWrtM;
      end
    end
  end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed, table-driven bench for mem_access_ctrl (TIMEOUT_CYC=4) plus a
// hand-written reset-during-WAIT sequence.
module tb_mem_access_ctrl;

  logic        clk;
  logic        rst;
  logic        readEnM, memWrtM;
  logic [15:0] aluFinalM, wrtDataM;
  logic        mem_en, mem_wr;
  logic [15:0] mem_addr, mem_wdata;
  logic        mem_stall, mem_done;
  logic [15:0] mem_rdata;
  logic        stallM;
  logic [15:0] readDataM;
  logic        errM;

  int checks;
  int failures;

  typedef struct {
    logic        rd;
    logic        wr;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic        stl;
    logic        dn;
    logic [15:0] rdata;
    logic        e_en;
    logic        e_wr;
    logic [15:0] e_addr;
    logic [15:0] e_wdata;
    logic        e_stall;
    logic [15:0] e_rd;
    logic        e_err;
  } vec_t;

  vec_t tbl[$];

  mem_access_ctrl #(
    .TIMEOUT_CYC(4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .readEnM   (readEnM),
    .memWrtM   (memWrtM),
    .aluFinalM (aluFinalM),
    .wrtDataM  (wrtDataM),
    .mem_en    (mem_en),
    .mem_wr    (mem_wr),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_stall (mem_stall),
    .mem_done  (mem_done),
    .mem_rdata (mem_rdata),
    .stallM    (stallM),
    .readDataM (readDataM),
    .errM      (errM)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mk(input logic rd, input logic wr, input logic [15:0] addr,
                              input logic [15:0] wdata, input logic stl, input logic dn,
                              input logic [15:0] rdata, input logic e_en, input logic e_wr,
                              input logic [15:0] e_addr, input logic [15:0] e_wdata,
                              input logic e_stall, input logic [15:0] e_rd, input logic e_err);
    vec_t v;
    v.rd = rd; v.wr = wr; v.addr = addr; v.wdata = wdata;
    v.stl = stl; v.dn = dn; v.rdata = rdata;
    v.e_en = e_en; v.e_wr = e_wr; v.e_addr = e_addr; v.e_wdata = e_wdata;
    v.e_stall = e_stall; v.e_rd = e_rd; v.e_err = e_err;
    return v;
  endfunction

  task automatic applyStimulus(input vec_t v);
    readEnM   = v.rd;
    memWrtM   = v.wr;
    aluFinalM = v.addr;
    wrtDataM  = v.wdata;
    mem_stall = v.stl;
    mem_done  = v.dn;
    mem_rdata = v.rdata;
  endtask

  task automatic checkOutput(input string name, input int idx,
                             input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s[%0d]: got %h, expected %h", name, idx, act, exp);
    end
  endtask

  task automatic checkAll(input int idx, input vec_t v);
    checkOutput("mem_en",    idx, {15'd0, mem_en},  {15'd0, v.e_en});
    checkOutput("mem_wr",    idx, {15'd0, mem_wr},  {15'd0, v.e_wr});
    checkOutput("mem_addr",  idx, mem_addr,         v.e_addr);
    checkOutput("mem_wdata", idx, mem_wdata,        v.e_wdata);
    checkOutput("stallM",    idx, {15'd0, stallM},  {15'd0, v.e_stall});
    checkOutput("readDataM", idx, readDataM,        v.e_rd);
    checkOutput("errM",      idx, {15'd0, errM},    {15'd0, v.e_err});
  endtask

  task automatic runVector(input int idx, input vec_t v);
    applyStimulus(v);
    #1;
    checkAll(idx, v);
    @(posedge clk);
    #1;
  endtask

`ifdef MEM_ACCESS_ALIGN_CHK_EN
  localparam logic        ODD_EN   = 1'b0;
  localparam logic [15:0] ODD_ADDR = 16'h0000;
  localparam logic [15:0] ODD_RD   = 16'hA5A5;
  localparam logic        ODD_ERR  = 1'b1;
`else
  localparam logic        ODD_EN   = 1'b1;
  localparam logic [15:0] ODD_ADDR = 16'h0011;
  localparam logic [15:0] ODD_RD   = 16'h0F0F;
  localparam logic        ODD_ERR  = 1'b0;
`endif

  initial begin
    vec_t v;
    checks   = 0;
    failures = 0;

    //            rd wr addr      wdata     st dn rdata     en wr e_addr    e_wdata   stl e_rd      err
    // load hit, then a stale done in IDLE
    tbl.push_back(mk(1, 0, 16'h0010, 16'h0000, 0, 1, 16'hBEEF, 1, 0, 16'h0010, 16'h0000, 0, 16'hBEEF, 0));
    tbl.push_back(mk(0, 0, 16'h0000, 16'h0000, 0, 1, 16'h5555, 0, 0, 16'h0000, 16'h0000, 0, 16'hBEEF, 0));
    // load miss, done three cycles after issue
    tbl.push_back(mk(1, 0, 16'h0030, 16'h0000, 0, 0, 16'h0000, 1, 0, 16'h0030, 16'h0000, 1, 16'hBEEF, 0));
    tbl.push_back(mk(1, 0, 16'h0030, 16'h0000, 0, 0, 16'h0000, 0, 0, 16'h0000, 16'h0000, 1, 16'hBEEF, 0));
    tbl.push_back(mk(1, 0, 16'h0030, 16'h0000, 0, 0, 16'h0000, 0, 0, 16'h0000, 16'h0000, 1, 16'hBEEF, 0));
    tbl.push_back(mk(1, 0, 16'h0030, 16'h0000, 0, 1, 16'h1234, 0, 0, 16'h0000, 16'h0000, 0, 16'h1234, 0));
    // busy twice, then miss; live address disturbed during RETRY
    tbl.push_back(mk(1, 0, 16'h0020, 16'h0000, 1, 0, 16'h0000, 1, 0, 16'h0020, 16'h0000, 1, 16'h1234, 0));
    tbl.push_back(mk(1, 0, 16'h0ABC, 16'h0000, 1, 0, 16'h0000, 1, 0, 16'h0020, 16'h0000, 1, 16'h1234, 0));
    tbl.push_back(mk(1, 0, 16'h0ABC, 16'h0000, 0, 0, 16'h0000, 1, 0, 16'h0020, 16'h0000, 1, 16'h1234, 0));
    tbl.push_back(mk(1, 0, 16'h0020, 16'h0000, 0, 1, 16'h7777, 0, 0, 16'h0000, 16'h0000, 0, 16'h7777, 0));
    // store hit then load hit, back to back
    tbl.push_back(mk(0, 1, 16'h0040, 16'hA5A5, 0, 1, 16'hDEAD, 1, 1, 16'h0040, 16'hA5A5, 0, 16'h7777, 0));
    tbl.push_back(mk(1, 0, 16'h0040, 16'h0000, 0, 1, 16'hA5A5, 1, 0, 16'h0040, 16'h0000, 0, 16'hA5A5, 0));
    // load+store together: store wins; store miss leaves readDataM alone
    tbl.push_back(mk(1, 1, 16'h0050, 16'h1111, 0, 0, 16'h0000, 1, 1, 16'h0050, 16'h1111, 1, 16'hA5A5, 0));
    tbl.push_back(mk(1, 1, 16'h0050, 16'h1111, 0, 1, 16'h9999, 0, 0, 16'h0000, 16'h0000, 0, 16'hA5A5, 0));
    tbl.push_back(mk(0, 0, 16'h0000, 16'h0000, 0, 0, 16'h0000, 0, 0, 16'h0000, 16'h0000, 0, 16'hA5A5, 0));
    // odd address: passed through by default, rejected when the check is built in
    tbl.push_back(mk(1, 0, 16'h0011, 16'h0000, 0, 1, 16'h0F0F, ODD_EN, 0, ODD_ADDR, 16'h0000, 0, ODD_RD, ODD_ERR));
    tbl.push_back(mk(0, 0, 16'h0000, 16'h0000, 0, 0, 16'h0000, 0, 0, 16'h0000, 16'h0000, 0, ODD_RD, 0));
    // done on the terminal-count cycle wins over the timeout
    tbl.push_back(mk(1, 0, 16'h0070, 16'h0000, 0, 0, 16'h0000, 1, 0, 16'h0070, 16'h0000, 1, ODD_RD, 0));
    for (int k = 0; k < 4; k++)
      tbl.push_back(mk(1, 0, 16'h0070, 16'h0000, 0, 0, 16'h0000, 0, 0, 16'h0000, 16'h0000, 1, ODD_RD, 0));
    tbl.push_back(mk(1, 0, 16'h0070, 16'h0000, 0, 1, 16'h7070, 0, 0, 16'h0000, 16'h0000, 0, 16'h7070, 0));
    // timeout: issue, four WAIT cycles, abort on the fifth, late done dropped
    tbl.push_back(mk(1, 0, 16'h0060, 16'h0000, 0, 0, 16'h0000, 1, 0, 16'h0060, 16'h0000, 1, 16'h7070, 0));
    for (int k = 0; k < 4; k++)
      tbl.push_back(mk(1, 0, 16'h0060, 16'h0000, 0, 0, 16'h0000, 0, 0, 16'h0000, 16'h0000, 1, 16'h7070, 0));
    tbl.push_back(mk(1, 0, 16'h0060, 16'h0000, 0, 0, 16'h0000, 0, 0, 16'h0000, 16'h0000, 0, 16'h0000, 1));
    tbl.push_back(mk(0, 0, 16'h0000, 16'h0000, 0, 1, 16'h4444, 0, 0, 16'h0000, 16'h0000, 0, 16'h0000, 0));
    tbl.push_back(mk(0, 0, 16'h0000, 16'h0000, 0, 0, 16'h0000, 0, 0, 16'h0000, 16'h0000, 0, 16'h0000, 0));

    rst = 1'b0;
    applyStimulus(mk(1, 0, 16'h0010, 16'h1234, 0, 1, 16'hFFFF, 0, 0, 0, 0, 0, 0, 0));
    #1;
    checkAll(-1, mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 16'h0000, 16'h0000, 0, 16'h0000, 0));
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    applyStimulus(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    @(posedge clk);
    #1;

    $display("[TB] running %0d table vectors", tbl.size());
    foreach (tbl[i]) runVector(i, tbl[i]);

    // Reset while WAITing: outputs drop at once, no error pulse, then IDLE.
    runVector(100, mk(1, 0, 16'h0080, 16'h0000, 0, 0, 16'h0000, 1, 0, 16'h0080, 16'h0000, 1, 16'h0000, 0));
    runVector(101, mk(1, 0, 16'h0080, 16'h0000, 0, 0, 16'h0000, 0, 0, 16'h0000, 16'h0000, 1, 16'h0000, 0));
    v = mk(1, 0, 16'h0080, 16'h0000, 0, 1, 16'hCAFE, 0, 0, 16'h0000, 16'h0000, 0, 16'h0000, 0);
    applyStimulus(v);
    rst = 1'b0;
    #1;
    checkAll(102, v);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    applyStimulus(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    @(posedge clk);
    #1;
    runVector(103, mk(0, 0, 16'h0000, 16'h0000, 0, 1, 16'h3333, 0, 0, 16'h0000, 16'h0000, 0, 16'h0000, 0));
    runVector(104, mk(1, 0, 16'h0090, 16'h0000, 0, 1, 16'h2468, 1, 0, 16'h0090, 16'h0000, 0, 16'h2468, 0));

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
